// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states, frame size and baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  function automatic int unsigned calc_div(input int unsigned clk, input int unsigned baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with configurable reset value.
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling, single-entry holding register with valid/ready,
// frame-error pulse and sticky overrun.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DIV      = calc_div(CLK_FREQ, BAUD)
) (
  input  logic       clk50mhz,
  input  logic       sys_rst_n,
  input  logic       rxd_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  input  logic       clr_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] HalfLoad = CntW'(DIV / 2 - 1);
  localparam logic [CntW-1:0] FullLoad = CntW'(DIV - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);

  logic rxd_s;
  logic rxd_h_q;

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver;
  logic                 ferr_d, ferr_q;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 tick;

  sync_2ff #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk_i  (clk50mhz),
    .rst_ni (sys_rst_n),
    .d_i    (rxd_in),
    .q_o    (rxd_s)
  );

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxd_s && rxd_h_q) begin
          state_d = StStart;
          cnt_d   = HalfLoad;
        end
      end
      StStart: begin
        if (tick) begin
          cnt_d = FullLoad;
          if (rxd_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (tick) begin
          shift_d[idx_q] = rxd_s;
          cnt_d          = FullLoad;
          idx_d          = idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        if (tick) begin
          cnt_d = FullLoad;
          if (rxd_s) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StBreak: begin
        // Held-low line must return high before another start bit can be seen.
        if (rxd_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_err) begin
      ovr_d = 1'b0;
    end
    if (deliver) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk50mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_h_q <= 1'b1;
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rxd_h_q <= rxd_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DIV=10: table of single frames plus hand-written
// sequences for latency, overrun, glitch, break, coincident delivery and mid-frame reset.
module tb_uart_rx_core;

  localparam int DIV = 10;

  logic       clk50mhz;
  logic       sys_rst_n;
  logic       rxd_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       clr_err;
  logic       rx_busy;

  uart_rx_core #(
    .CLK_FREQ (50000000),
    .BAUD     (5000000)
  ) dut (
    .clk50mhz     (clk50mhz),
    .sys_rst_n    (sys_rst_n),
    .rxd_in       (rxd_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .clr_err      (clr_err),
    .rx_busy      (rx_busy)
  );

  initial clk50mhz = 1'b0;
  always #5 clk50mhz = ~clk50mhz;

  // Event counters seen at the active edge; tests compare deltas against constants.
  int         hs_cnt   = 0;
  int         ferr_cnt = 0;
  int         vcyc_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  always @(posedge clk50mhz) begin
    if (rx_valid && rx_ready) begin
      hs_cnt    <= hs_cnt + 1;
      last_byte <= rx_data;
    end
    if (rx_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (rx_valid) vcyc_cnt <= vcyc_cnt + 1;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Called right after a negedge; each bit is held DIV clocks.
  task automatic send_bits(input logic [9:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      rxd_in = frame[i];
      repeat (DIV) @(negedge clk50mhz);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_bits({stop, data, 1'b0}, 10);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_hs;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];
  int   b_hs, b_f, b_v, lat;

  initial begin
    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_hs: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_hs: 1, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_hs: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h81, stop: 1'b1, exp_data: 8'h81, exp_hs: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'hC3, stop: 1'b0, exp_data: 8'h00, exp_hs: 0, exp_ferr: 1};
    vecs[5] = '{data: 8'hA5, stop: 1'b1, exp_data: 8'hA5, exp_hs: 1, exp_ferr: 0};
    vecs[6] = '{data: 8'h3C, stop: 1'b1, exp_data: 8'h3C, exp_hs: 1, exp_ferr: 0};

    sys_rst_n = 1'b0;
    rxd_in    = 1'b1;
    rx_ready  = 1'b0;
    clr_err   = 1'b0;
    repeat (3) @(negedge clk50mhz);
    check("reset_data", 32'(rx_data), 32'h00);
    check("reset_flags", 32'({rx_valid, rx_frame_err, rx_overrun, rx_busy}), 32'h0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge clk50mhz);

    // Table: one frame each, consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      b_hs = hs_cnt;
      b_f  = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      rxd_in = 1'b1;
      repeat (2 * DIV) @(negedge clk50mhz);
      check($sformatf("vec%0d_accepts", i), 32'(hs_cnt - b_hs), 32'(vecs[i].exp_hs));
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - b_f), 32'(vecs[i].exp_ferr));
      if (vecs[i].exp_hs != 0) check($sformatf("vec%0d_data", i), 32'(last_byte),
                                     32'(vecs[i].exp_data));
      check($sformatf("vec%0d_idle", i), 32'({rx_busy, rx_overrun, rx_valid}), 32'h0);
    end

    // Latency: 2 sync + 95 to stop sample + 1 register = first seen high after clock 98.
    b_v = vcyc_cnt;
    b_f = ferr_cnt;
    lat = -1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int k = 1; k <= 200; k++) begin
          @(negedge clk50mhz);
          if (rx_valid && lat < 0) lat = k;
        end
      end
    join
    check("latency_clocks", 32'(lat), 32'd98);
    check("valid_one_cycle", 32'(vcyc_cnt - b_v), 32'd1);
    check("latency_data", 32'(last_byte), 32'h55);
    check("latency_no_ferr", 32'(ferr_cnt - b_f), 32'd0);

    // Back-to-back with consumer stalled: second byte overruns.
    rx_ready = 1'b0;
    send_frame(8'hA5, 1'b1);
    check("b2b_first_valid", 32'({rx_valid, rx_overrun}), 32'b10);
    check("b2b_first_data", 32'(rx_data), 32'hA5);
    send_frame(8'h3C, 1'b1);
    repeat (2 * DIV) @(negedge clk50mhz);
    check("b2b_overrun", 32'({rx_valid, rx_overrun}), 32'b11);
    check("b2b_data_kept", 32'(rx_data), 32'hA5);
    clr_err = 1'b1;
    @(negedge clk50mhz);
    clr_err = 1'b0;
    check("clr_err", 32'({rx_valid, rx_overrun}), 32'b10);
    rx_ready = 1'b1;
    @(negedge clk50mhz);
    check("b2b_read", 32'(last_byte), 32'hA5);
    check("b2b_drained", 32'(rx_valid), 32'd0);

    // Start-bit glitch of 3 clocks.
    b_hs = hs_cnt;
    b_f  = ferr_cnt;
    rxd_in = 1'b0;
    repeat (3) @(negedge clk50mhz);
    rxd_in = 1'b1;
    check("glitch_busy", 32'(rx_busy), 32'd1);
    repeat (7) @(negedge clk50mhz);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    repeat (3 * DIV) @(negedge clk50mhz);
    check("glitch_no_event", 32'({hs_cnt - b_hs, ferr_cnt - b_f}), 32'h0);

    // Framing error followed by a long break.
    b_hs = hs_cnt;
    b_f  = ferr_cnt;
    send_frame(8'hFF, 1'b0);
    repeat (300) @(negedge clk50mhz);
    check("break_ferr_once", 32'(ferr_cnt - b_f), 32'd1);
    check("break_no_byte", 32'(hs_cnt - b_hs), 32'd0);
    check("break_busy", 32'(rx_busy), 32'd1);
    rxd_in = 1'b1;
    repeat (2 * DIV) @(negedge clk50mhz);
    check("break_exit", 32'(rx_busy), 32'd0);
    send_frame(8'h12, 1'b1);
    repeat (2 * DIV) @(negedge clk50mhz);
    check("after_break_count", 32'(hs_cnt - b_hs), 32'd1);
    check("after_break_data", 32'(last_byte), 32'h12);

    // Delivery coinciding with a handshake on the held byte.
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    check("coinc_first", 32'({rx_valid, rx_data}), 32'h111);
    b_hs = hs_cnt;
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (97) @(negedge clk50mhz);
        rx_ready = 1'b1;
        @(negedge clk50mhz);
        rx_ready = 1'b0;
        check("coinc_reload", 32'({rx_valid, rx_data}), 32'h122);
        check("coinc_no_overrun", 32'(rx_overrun), 32'd0);
        check("coinc_accepted_old", 32'({hs_cnt - b_hs, 24'(last_byte)}), 32'h0100_0011);
      end
    join

    // Reset in the middle of a frame.
    b_f = ferr_cnt;
    send_bits({1'b1, 8'h81, 1'b0}, 4);
    check("pre_reset_busy", 32'(rx_busy), 32'd1);
    sys_rst_n = 1'b0;
    rxd_in    = 1'b1;
    repeat (2) @(negedge clk50mhz);
    check("midreset_data", 32'(rx_data), 32'h00);
    check("midreset_flags", 32'({rx_valid, rx_frame_err, rx_overrun, rx_busy}), 32'h0);
    sys_rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk50mhz);
    rx_ready = 1'b1;
    b_hs = hs_cnt;
    send_frame(8'h7E, 1'b1);
    repeat (2 * DIV) @(negedge clk50mhz);
    check("post_reset_count", 32'(hs_cnt - b_hs), 32'd1);
    check("post_reset_data", 32'(last_byte), 32'h7E);
    check("post_reset_no_ferr", 32'(ferr_cnt - b_f), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receiver for the SoC console path. Converts the 8N1 asynchronous line driven into the top-level uart_txd_in pin into bytes with a valid/ready handshake.
- Counterpart of the SoC UART transmitter that drives uart_rxd_out.
- Sits between the pad and the peripheral bus register block. Also instantiated in the board-level bench to decode uart_rxd_out for self-checking.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DIV, CLK_FREQ/BAUD (integer, truncated; 434 at defaults), clocks per bit. Must be >= 4.

Ports:
- clk50mhz  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rxd_in  in  1  raw serial line, idle high, asynchronous to clk50mhz.
- rx_data  out  8  received byte, LSB first on the wire.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid&rx_ready.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- rx_overrun  out  1  sticky: a byte was dropped.
- clr_err  in  1  clears rx_overrun.
- rx_busy  out  1  FSM not in IDLE.

Behaviour:
- Interface: one clock (clk50mhz). Reset sys_rst_n is asynchronous, active-low.
- Reset values: rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, FSM=IDLE, synchroniser flops=1.
- Reset deasserted mid-frame: the partial frame is lost. The FSM restarts in IDLE and waits for a falling edge.
- Synchroniser: rxd_in passes through 2 flops to give rxd_s, plus 1 history flop. A falling edge is rxd_s=0 with the history flop =1.
- Baud counter: width clog2(DIV). It reloads on every state entry and on every sample.
- FSM states:
  - IDLE: on a falling edge, go to START and load the counter with DIV/2 - 1.
  - START: when the counter reaches 0, sample rxd_s. If 1 (glitch), go to IDLE with no flags. If 0, go to DATA with bit index 0 and counter DIV-1.
  - DATA: every DIV cycles, sample rxd_s into shift[index]; index increments. After index 7 is sampled, go to STOP.
  - STOP: sample after DIV cycles.
    - rxd_s=1: deliver the byte and go to IDLE.
    - rxd_s=0: pulse rx_frame_err for 1 cycle, discard the byte, go to BREAK.
  - BREAK: wait for rxd_s=1, then go to IDLE. This prevents a held-low line from being decoded as 0x00 frames.
- Timing: the stop sample occurs 9*DIV + DIV/2 clocks after the detected edge. rx_valid rises on the clock after the stop sample. Synchroniser delay from the pin is 2 clocks.
- Delivery and handshake:
  - Holding register, single entry.
  - On delivery with rx_valid=0: load rx_data, set rx_valid.
  - rx_valid&rx_ready with no delivery: clear rx_valid.
  - Delivery in the same cycle as rx_valid&rx_ready: load the new byte, rx_valid stays 1.
  - Delivery while rx_valid=1 and rx_ready=0: keep the old byte, set rx_overrun, drop the new byte.
  - rx_data is stable while rx_valid=1.
- rx_overrun clears on clr_err. If clr_err and a new overrun occur in the same cycle, set wins.
- A new falling edge in IDLE immediately after STOP is accepted. Back-to-back frames with no idle gap must decode.
- rx_busy=1 in START/DATA/STOP/BREAK.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, STOP, BREAK.
  - Function calc_div(clk, baud).
  - Constant DATA_BITS=8.
  - Shared with the transmitter.
- One natural sub-module: sync_2ff (2-flop synchroniser, reset value parameter = 1), reused for other asynchronous inputs.

Test Plan (CLK_FREQ=50000000, BAUD=5000000, DIV=10):
- Single frame 0x55 with rx_ready held 1: rx_data=0x55, rx_valid high exactly 1 cycle, 95 clocks after the edge (+2 sync), no flags.
- Frames 0xA5 then 0x3C back-to-back (no idle gap), rx_ready=0: first read gives 0xA5. The second completion sets rx_overrun=1 and rx_data stays 0xA5. clr_err clears rx_overrun.
- Start-bit glitch (line low for 3 clocks): no rx_valid, no rx_frame_err, FSM back in IDLE, rx_busy=0 by clock 7.
- Frame 0xFF with stop bit forced 0, then line held low for 300 clocks: one rx_frame_err pulse, no rx_valid, no further frames while low. After the line returns high, frame 0x12 decodes correctly.
- Delivery coinciding with rx_valid&rx_ready (rx_ready asserted exactly on the delivery clock): new byte loaded, rx_valid remains 1, rx_overrun=0.
- sys_rst_n asserted mid-DATA of 0x81, released, then frame 0x7E sent: all outputs 0 during reset, next output 0x7E only.
